// File: rtl/lsu_master_if.sv
// Word-aligned req/ack data-memory bus between the load/store unit and memory.
// The LSU owns request, write enable, address, byte enables and store data.
// The memory answers with an acknowledge and, for loads, the read word.
interface lsu_master_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/lsu_master.sv
// Load/store initiator between the RV32I core and a word-addressed data memory.
// One request at a time: legality check, then a req/ack memory access with
// byte enables, then a one-cycle done pulse with error flags.
// Load data is lane-selected and sign/zero-extended.
// Accesses with no acknowledge are aborted after TIMEOUT_CYCLES cycles.
module lsu_master #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         is_store,
   input  logic [2:0]   funct3,
   input  logic [31:0]  addr,
   input  logic [31:0]  wdata,
   output logic         busy,
   output logic         done,
   output logic [1:0]   err,
   output logic [31:0]  rdata,
   lsu_master_if.master mem
);

   localparam int               CNT_W    = 10;
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q;
   logic              busy_q;
   logic              done_q;
   logic [1:0]        err_q;
   logic [31:0]       rdata_q;
   logic              req_q;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdat_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;

   logic              legal_d;
   logic [3:0]        be_d;
   logic [31:0]       wdat_d;
   logic [CNT_W-1:0]  cnt_d;
   logic [31:0]       ldata_d;

   // Width code / alignment check; BU and HU exist only for loads.
   function automatic logic access_legal(input logic st, input logic [2:0] f3,
                                         input logic [1:0] o);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = ~o[0];
         3'b010:  ok = (o == 2'b00);
         3'b100:  ok = ~st;
         3'b101:  ok = ~st & ~o[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte enables from the access size (funct3[1:0]) and the byte offset.
   function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] o);
      logic [3:0] be;
      case (sz)
         2'b00:   be = 4'b0001 << o;
         2'b01:   be = o[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate the store operand into every lane so the enabled lane carries it.
   function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      case (sz)
         2'b00:   r = {4{wd[7:0]}};
         2'b01:   r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   // Pick the addressed byte/half out of the read word and extend it.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(w >> {o, 3'b000});
      h = o[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'd0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'd0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Decode the incoming request and prepare the next counter / load result.
   always_comb begin
      legal_d = access_legal(is_store, funct3, addr[1:0]);
      be_d    = byte_en(funct3[1:0], addr[1:0]);
      wdat_d  = is_store ? store_lanes(funct3[1:0], wdata) : 32'd0;
      cnt_d   = cnt_q + CNT_W'(1);
      ldata_d = load_extend(f3_q, off_q, mem.mem_rdata);
   end

   // Request FSM with every output registered; ack beats timeout on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= ERR_OK;
         rdata_q <= 32'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdat_q  <= 32'd0;
         cnt_q   <= '0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (!legal_d) begin
                     state_q <= RESP;
                     done_q  <= 1'b1;
                     err_q   <= ERR_ILLEGAL;
                  end else begin
                     state_q <= BUSY;
                     req_q   <= 1'b1;
                     we_q    <= is_store;
                     addr_q  <= {addr[31:2], 2'b00};
                     be_q    <= be_d;
                     wdat_q  <= wdat_d;
                     cnt_q   <= '0;
                     f3_q    <= funct3;
                     off_q   <= addr[1:0];
                  end
               end
            end
            BUSY: begin
               cnt_q <= cnt_d;
               if (mem.mem_ack || (cnt_d >= TO_LIMIT)) begin
                  state_q <= RESP;
                  done_q  <= 1'b1;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  addr_q  <= 32'd0;
                  be_q    <= 4'd0;
                  wdat_q  <= 32'd0;
                  if (mem.mem_ack) begin
                     err_q <= ERR_OK;
                     if (!we_q) rdata_q <= ldata_d;
                  end else begin
                     err_q   <= ERR_TIMEOUT;
                     rdata_q <= 32'd0;
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign rdata         = rdata_q;
   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_wdata = wdat_q;

endmodule

// File: tb/tb_lsu_master.sv
// Self-checking bench for lsu_master: scoreboard of expected bus/response
// values, one task per scenario, memory responder built into the access task.
`timescale 1ns/1ps
module tb_lsu_master;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [1:0]  err;
   logic [31:0] rdata;

   lsu_master_if mem_if();

   lsu_master #(.TIMEOUT_CYCLES(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .is_store (is_store),
      .funct3   (funct3),
      .addr     (addr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .rdata    (rdata),
      .mem      (mem_if)
   );

   always #5 clk = ~clk;

   // bus = {req_seen, we, addr, be, wdata}; resp = {err, rdata}
   typedef struct {
      logic [69:0] bus;
      logic [33:0] resp;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [69:0] obs_bus;
   logic [33:0] obs_resp;
   int          obs_lat;
   logic        got_done;
   logic        obs_unstable;
   logic        obs_busy_after;
   logic [31:0] model_rdata;

   // Issue one request at a negedge and act as the memory: ack in the
   // ack_after-th request cycle (-1 never). Records what the DUT did.
   task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input int ack_after);
      int   req_cycles;
      logic seen;
      req_cycles = 0;
      seen = 1'b0;
      got_done = 1'b0; obs_bus = '0; obs_resp = '0; obs_lat = -1;
      obs_unstable = 1'b0; obs_busy_after = 1'bx;
      start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 40 && !got_done; n++) begin
         if (done) begin
            got_done = 1'b1;
            obs_lat  = n;
            obs_resp = {err, rdata};
         end else begin
            if (mem_if.mem_req) begin
               if (!seen) begin
                  obs_bus = {1'b1, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata};
                  seen = 1'b1;
               end else if (obs_bus !== {1'b1, mem_if.mem_we, mem_if.mem_addr,
                                         mem_if.mem_be, mem_if.mem_wdata}) begin
                  obs_unstable = 1'b1;
               end
               if (req_cycles == ack_after) begin
                  mem_if.mem_ack   = 1'b1;
                  mem_if.mem_rdata = word;
               end
               req_cycles++;
            end
            @(negedge clk);
            mem_if.mem_ack   = 1'b0;
            mem_if.mem_rdata = 32'h5A5A_5A5A;
         end
      end
      if (got_done) begin
         @(negedge clk);
         obs_busy_after = busy;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, err, rdata} !== 36'd0) begin
         failures++;
         $display("FAIL reset_core_outputs: got %h want 0", {busy, done, err, rdata});
      end
      checks++;
      if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata} !== 70'd0) begin
         failures++;
         $display("FAIL reset_mem_outputs: got %h want 0",
                  {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata});
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, mem_if.mem_req} !== 3'b000) begin
         failures++;
         $display("FAIL reset_idle: got %b want 000", {busy, done, mem_if.mem_req});
      end
      model_rdata = 32'd0;
   endtask

   task automatic test_load_word;
      exp_t e;
      exp_q.push_back('{{1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0}, {2'b00, 32'hDEAD_BEEF}, 1});
      access(1'b0, 3'b010, 32'h10, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0);
      model_rdata = 32'hDEAD_BEEF;
      e = exp_q.pop_front();
      checks++;
      if (got_done !== 1'b1) begin failures++; $display("FAIL lw_done: got %b want 1", got_done); end
      checks++;
      if (obs_bus !== e.bus) begin failures++; $display("FAIL lw_bus: got %h want %h", obs_bus, e.bus); end
      checks++;
      if (obs_resp !== e.resp) begin failures++; $display("FAIL lw_resp: got %h want %h", obs_resp, e.resp); end
      checks++;
      if (obs_lat !== e.lat) begin failures++; $display("FAIL lw_latency: got %0d want %0d", obs_lat, e.lat); end
      checks++;
      if (obs_busy_after !== 1'b0) begin
         failures++; $display("FAIL lw_busy_after_done: got %b want 0", obs_busy_after);
      end
   endtask

   task automatic test_load_ext;
      logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
      logic [31:0] as  [6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h11, 32'h10};
      logic [3:0]  bes [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010, 4'b0011};
      logic [31:0] res [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_80FF, 32'h0000_007F, 32'h0000_7F01};
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back('{{1'b1, 1'b0, 32'h0000_0010, bes[i], 32'h0}, {2'b00, res[i]}, i + 1});
         access(1'b0, f3s[i], as[i], 32'h0, 32'h80FF_7F01, i);
         model_rdata = res[i];
         e = exp_q.pop_front();
         checks++;
         if (obs_bus !== e.bus) begin
            failures++; $display("FAIL ld_ext%0d_bus: got %h want %h", i, obs_bus, e.bus);
         end
         checks++;
         if (obs_resp !== e.resp) begin
            failures++; $display("FAIL ld_ext%0d_resp: got %h want %h", i, obs_resp, e.resp);
         end
         checks++;
         if (obs_lat !== e.lat) begin
            failures++; $display("FAIL ld_ext%0d_latency: got %0d want %0d", i, obs_lat, e.lat);
         end
      end
   endtask

   task automatic test_store;
      logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001};
      logic [31:0] as  [5] = '{32'h21, 32'h22, 32'h24, 32'h27, 32'h20};
      logic [31:0] mas [5] = '{32'h20, 32'h20, 32'h24, 32'h24, 32'h20};
      logic [3:0]  bes [5] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000, 4'b0011};
      logic [31:0] wds [5] = '{32'hABAB_ABAB, 32'h56AB_56AB, 32'h1234_56AB,
                               32'hABAB_ABAB, 32'h56AB_56AB};
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back('{{1'b1, 1'b1, mas[i], bes[i], wds[i]}, {2'b00, model_rdata}, 2});
         access(1'b1, f3s[i], as[i], 32'h1234_56AB, 32'hCAFE_F00D, 1);
         e = exp_q.pop_front();
         checks++;
         if (obs_bus !== e.bus) begin
            failures++; $display("FAIL st%0d_bus: got %h want %h", i, obs_bus, e.bus);
         end
         checks++;
         if (obs_resp !== e.resp) begin
            failures++; $display("FAIL st%0d_resp: got %h want %h", i, obs_resp, e.resp);
         end
      end
   endtask

   task automatic test_illegal;
      logic        sts [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3s [7] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101, 3'b010, 3'b001};
      logic [31:0] as  [7] = '{32'h02, 32'h01, 32'h10, 32'h10, 32'h13, 32'h01, 32'h05};
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back('{70'd0, {2'b01, model_rdata}, 0});
         access(sts[i], f3s[i], as[i], 32'h1111_2222, 32'h3333_4444, 0);
         e = exp_q.pop_front();
         checks++;
         if (obs_bus !== e.bus) begin
            failures++; $display("FAIL illegal%0d_no_access: got %h want %h", i, obs_bus, e.bus);
         end
         checks++;
         if (obs_resp !== e.resp || obs_lat !== e.lat) begin
            failures++;
            $display("FAIL illegal%0d_resp: got %h lat %0d want %h lat %0d",
                     i, obs_resp, obs_lat, e.resp, e.lat);
         end
      end
   endtask

   task automatic test_timeout;
      exp_t e;
      // Ack in the last cycle before the limit wins over the timeout.
      exp_q.push_back('{{1'b1, 1'b0, 32'h0000_0040, 4'b1111, 32'h0}, {2'b00, 32'h1357_2468}, TO});
      access(1'b0, 3'b010, 32'h40, 32'h0, 32'h1357_2468, TO - 1);
      e = exp_q.pop_front();
      checks++;
      if (obs_resp !== e.resp || obs_lat !== e.lat) begin
         failures++;
         $display("FAIL ack_at_limit: got %h lat %0d want %h lat %0d", obs_resp, obs_lat, e.resp, e.lat);
      end
      // No ack at all: abort with err=10 and rdata cleared.
      exp_q.push_back('{{1'b1, 1'b0, 32'h0000_0044, 4'b1111, 32'h0}, {2'b10, 32'h0}, TO});
      access(1'b0, 3'b010, 32'h44, 32'h0, 32'h0, -1);
      model_rdata = 32'd0;
      e = exp_q.pop_front();
      checks++;
      if (obs_resp !== e.resp || obs_lat !== e.lat) begin
         failures++;
         $display("FAIL timeout_resp: got %h lat %0d want %h lat %0d", obs_resp, obs_lat, e.resp, e.lat);
      end
      checks++;
      if (obs_bus !== e.bus || obs_unstable !== 1'b0) begin
         failures++;
         $display("FAIL timeout_bus_stable: got %h unstable %b want %h unstable 0",
                  obs_bus, obs_unstable, e.bus);
      end
      checks++;
      if (mem_if.mem_req !== 1'b0) begin
         failures++; $display("FAIL timeout_req_dropped: got %b want 0", mem_if.mem_req);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] words [2] = '{32'h1111_1111, 32'h2222_2222};
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{{1'b1, 1'b0, 32'h30 + 32'(4 * i), 4'b1111, 32'h0}, {2'b00, words[i]}, 1});
         access(1'b0, 3'b010, 32'h30 + 32'(4 * i), 32'h0, words[i], 0);
         model_rdata = words[i];
         e = exp_q.pop_front();
         checks++;
         if (obs_bus !== e.bus || obs_resp !== e.resp || obs_lat !== e.lat) begin
            failures++;
            $display("FAIL b2b%0d: got %h/%h lat %0d want %h/%h lat %0d",
                     i, obs_bus, obs_resp, obs_lat, e.bus, e.resp, e.lat);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic stray_done;
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40; wdata = 32'h0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; addr = 32'h80;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, mem_if.mem_req, mem_if.mem_addr} !== {2'b11, 32'h40}) begin
         failures++;
         $display("FAIL start_while_busy: got %h want %h",
                  {busy, mem_if.mem_req, mem_if.mem_addr}, {2'b11, 32'h40});
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({busy, done, err, rdata, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr,
           mem_if.mem_be, mem_if.mem_wdata} !== 106'd0) begin
         failures++;
         $display("FAIL reset_mid_outputs: got %h want 0",
                  {busy, done, err, rdata, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr,
                   mem_if.mem_be, mem_if.mem_wdata});
      end
      stray_done = 1'b0;
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h7777_7777;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) stray_done = 1'b1;
      end
      mem_if.mem_ack = 1'b0;
      checks++;
      if (stray_done !== 1'b0) begin
         failures++; $display("FAIL late_ack_ignored: got %b want 0", stray_done);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
      addr = 32'h0; wdata = 32'h0;
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h5A5A_5A5A;
      model_rdata = 32'd0;
      test_reset();
      test_load_word();
      test_load_ext();
      test_store();
      test_illegal();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
